// File: rtl/carbon_cai_host_ring.sv
`default_nettype none
// ============================================================================
//  Module   : carbon_cai_host_ring
//  Purpose  : Host-side in-order CAI ring manager. Allocates submit slots and
//             tags, rings the submit doorbell, tracks completion messages and
//             exposes the head completion record with its expected tag.
//             Flags tag mismatch, spurious completion, bad commit and timeout.
//  Revision : 1.0  initial release
// ============================================================================
module carbon_cai_host_ring #(
    parameter int          SUBMIT_DEPTH      = 4,
    parameter int          COMP_DEPTH        = 4,
    parameter int          SUBMIT_DESC_BYTES = 64,
    parameter int          COMP_REC_BYTES    = 32,
    parameter logic [31:0] TAG_INIT          = 32'h1,
    parameter int          TIMEOUT_CYCLES    = 20000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cfg_enable,
    input  logic [63:0] cfg_submit_base,
    input  logic [63:0] cfg_comp_base,
    input  logic [15:0] cfg_context,
    input  logic        alloc_valid,
    output logic        alloc_ready,
    output logic [31:0] alloc_tag,
    output logic [63:0] alloc_addr,
    input  logic        commit,
    output logic [63:0] cai_submit_base,
    output logic [31:0] cai_submit_size,
    output logic [15:0] cai_context_sel,
    output logic        cai_submit_doorbell,
    input  logic        cai_comp_msg,
    output logic        comp_valid,
    input  logic        comp_ready,
    output logic [63:0] comp_addr,
    output logic [31:0] comp_exp_tag,
    input  logic [31:0] comp_rd_tag,
    output logic [8:0]  outstanding,
    output logic        err_tag,
    output logic        err_spurious,
    output logic        err_commit,
    output logic        err_timeout,
    input  logic        err_clear
);

    localparam logic [8:0]  c_SUB_DEPTH = 9'(SUBMIT_DEPTH);
    localparam logic [8:0]  c_SUB_MASK  = 9'(SUBMIT_DEPTH - 1);
    localparam logic [63:0] c_COMP_MASK = 64'(COMP_DEPTH - 1);
    localparam logic [63:0] c_SUB_STRIDE  = 64'(SUBMIT_DESC_BYTES);
    localparam logic [63:0] c_COMP_STRIDE = 64'(COMP_REC_BYTES);
    localparam logic [31:0] c_TIMEOUT   = 32'(TIMEOUT_CYCLES);

    // Tag sequence skips zero so a zeroed record can never look valid.
    function automatic logic [31:0] f_next_tag(input logic [31:0] tag);
        return (tag == 32'hFFFF_FFFF) ? 32'h1 : tag + 32'h1;
    endfunction

    logic [8:0]  r_alloc_idx;
    logic [8:0]  r_commit_idx;
    logic [8:0]  r_retire_idx;
    logic [8:0]  r_pending;
    logic [31:0] r_issue_tag;
    logic [31:0] r_exp_tag;
    logic [31:0] r_timer;
    logic        r_doorbell;
    logic        r_err_tag;
    logic        r_err_spurious;
    logic        r_err_commit;
    logic        r_err_timeout;

    logic [8:0]  w_outstanding;
    logic [8:0]  w_inflight;
    logic        w_slot_open;
    logic        w_alloc_ready;
    logic        w_alloc_fire;
    logic        w_commit_ok;
    logic        w_commit_bad;
    logic        w_msg_ok;
    logic        w_msg_bad;
    logic        w_comp_valid;
    logic        w_retire;
    logic        w_tag_bad;
    logic        w_timer_clr;
    logic        w_timer_hit;

    // Ring occupancy and handshake qualification.
    always_comb begin
        w_outstanding = r_alloc_idx - r_retire_idx;
        w_inflight    = r_commit_idx - r_retire_idx - r_pending;
        // An allocated-but-uncommitted slot exists when alloc has run ahead of commit.
        w_slot_open   = (r_alloc_idx != r_commit_idx);
        // rst_n gating keeps the grant low while the synchronous reset is applied.
        w_alloc_ready = rst_n && cfg_enable && (w_outstanding < c_SUB_DEPTH) && !w_slot_open;
        w_alloc_fire  = alloc_valid && w_alloc_ready;
        w_commit_ok   = commit && w_slot_open;
        w_commit_bad  = commit && !w_slot_open;
        w_msg_ok      = cai_comp_msg && (w_inflight != 9'd0);
        w_msg_bad     = cai_comp_msg && (w_inflight == 9'd0);
        w_comp_valid  = (r_pending != 9'd0);
        w_retire      = w_comp_valid && comp_ready;
        w_tag_bad     = w_retire && (comp_rd_tag != r_exp_tag);
        // Any sign of progress (or nothing to wait for) restarts the watchdog.
        w_timer_clr   = cai_comp_msg || w_retire || err_clear || (w_inflight == 9'd0);
        // Flag on the same edge the count reaches the limit.
        w_timer_hit   = !w_timer_clr && (r_timer >= c_TIMEOUT - 32'd1);
    end

    // Ring indices and tag sequencers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_alloc_idx  <= 9'd0;
            r_commit_idx <= 9'd0;
            r_retire_idx <= 9'd0;
            r_issue_tag  <= TAG_INIT;
            r_exp_tag    <= TAG_INIT;
        end else begin
            if (w_alloc_fire) begin
                r_alloc_idx <= r_alloc_idx + 9'd1;
                r_issue_tag <= f_next_tag(r_issue_tag);
            end
            if (w_commit_ok) begin
                r_commit_idx <= r_commit_idx + 9'd1;
            end
            if (w_retire) begin
                r_retire_idx <= r_retire_idx + 9'd1;
                r_exp_tag    <= f_next_tag(r_exp_tag);
            end
        end
    end

    // Pending completions: a message and a retire in one cycle cancel out.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pending <= 9'd0;
        end else if (w_msg_ok && !w_retire) begin
            r_pending <= r_pending + 9'd1;
        end else if (w_retire && !w_msg_ok) begin
            r_pending <= r_pending - 9'd1;
        end
    end

    // No-progress watchdog; saturates at the limit.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_timer <= 32'd0;
        end else if (w_timer_clr) begin
            r_timer <= 32'd0;
        end else if (r_timer < c_TIMEOUT) begin
            r_timer <= r_timer + 32'd1;
        end
    end

    // Registered doorbell, one pulse per accepted commit.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_doorbell <= 1'b0;
        end else begin
            r_doorbell <= w_commit_ok;
        end
    end

    // Sticky error flags; a clear wins over a same-cycle set.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_err_tag      <= 1'b0;
            r_err_spurious <= 1'b0;
            r_err_commit   <= 1'b0;
            r_err_timeout  <= 1'b0;
        end else if (err_clear) begin
            r_err_tag      <= 1'b0;
            r_err_spurious <= 1'b0;
            r_err_commit   <= 1'b0;
            r_err_timeout  <= 1'b0;
        end else begin
            if (w_tag_bad)    r_err_tag      <= 1'b1;
            if (w_msg_bad)    r_err_spurious <= 1'b1;
            if (w_commit_bad) r_err_commit   <= 1'b1;
            if (w_timer_hit)  r_err_timeout  <= 1'b1;
        end
    end

    // Output mapping; addresses are base plus slot offset in 64-bit arithmetic.
    always_comb begin
        alloc_ready         = w_alloc_ready;
        alloc_tag           = r_issue_tag;
        alloc_addr          = cfg_submit_base + 64'(r_alloc_idx & c_SUB_MASK) * c_SUB_STRIDE;
        cai_submit_base     = cfg_submit_base;
        cai_submit_size     = 32'(SUBMIT_DEPTH);
        cai_context_sel     = cfg_context;
        cai_submit_doorbell = r_doorbell;
        comp_valid          = w_comp_valid;
        comp_addr           = cfg_comp_base + (64'(r_retire_idx) & c_COMP_MASK) * c_COMP_STRIDE;
        comp_exp_tag        = r_exp_tag;
        outstanding         = w_outstanding;
        err_tag             = r_err_tag;
        err_spurious        = r_err_spurious;
        err_commit          = r_err_commit;
        err_timeout         = r_err_timeout;
    end

endmodule
`default_nettype wire

// File: tb/tb_carbon_cai_host_ring.sv
`default_nettype none
// ============================================================================
//  Module   : tb_carbon_cai_host_ring
//  Purpose  : Directed and randomized checks of carbon_cai_host_ring against
//             a queue-based reference model of the ring.
//  Revision : 1.0  initial release
// ============================================================================
module tb_carbon_cai_host_ring;

    localparam int          P_SUB   = 4;
    localparam int          P_COMP  = 8;
    localparam int          P_SDB   = 64;
    localparam int          P_CRB   = 32;
    localparam logic [31:0] P_TAG0  = 32'hFFFF_FFFE;
    localparam int          P_TOUT  = 100;

    logic        clk;
    logic        rst_n;
    logic        cfg_enable;
    logic [63:0] cfg_submit_base;
    logic [63:0] cfg_comp_base;
    logic [15:0] cfg_context;
    logic        alloc_valid;
    logic        alloc_ready;
    logic [31:0] alloc_tag;
    logic [63:0] alloc_addr;
    logic        commit;
    logic [63:0] cai_submit_base;
    logic [31:0] cai_submit_size;
    logic [15:0] cai_context_sel;
    logic        cai_submit_doorbell;
    logic        cai_comp_msg;
    logic        comp_valid;
    logic        comp_ready;
    logic [63:0] comp_addr;
    logic [31:0] comp_exp_tag;
    logic [31:0] comp_rd_tag;
    logic [8:0]  outstanding;
    logic        err_tag;
    logic        err_spurious;
    logic        err_commit;
    logic        err_timeout;
    logic        err_clear;

    carbon_cai_host_ring #(
        .SUBMIT_DEPTH      (P_SUB),
        .COMP_DEPTH        (P_COMP),
        .SUBMIT_DESC_BYTES (P_SDB),
        .COMP_REC_BYTES    (P_CRB),
        .TAG_INIT          (P_TAG0),
        .TIMEOUT_CYCLES    (P_TOUT)
    ) u_dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .cfg_enable          (cfg_enable),
        .cfg_submit_base     (cfg_submit_base),
        .cfg_comp_base       (cfg_comp_base),
        .cfg_context         (cfg_context),
        .alloc_valid         (alloc_valid),
        .alloc_ready         (alloc_ready),
        .alloc_tag           (alloc_tag),
        .alloc_addr          (alloc_addr),
        .commit              (commit),
        .cai_submit_base     (cai_submit_base),
        .cai_submit_size     (cai_submit_size),
        .cai_context_sel     (cai_context_sel),
        .cai_submit_doorbell (cai_submit_doorbell),
        .cai_comp_msg        (cai_comp_msg),
        .comp_valid          (comp_valid),
        .comp_ready          (comp_ready),
        .comp_addr           (comp_addr),
        .comp_exp_tag        (comp_exp_tag),
        .comp_rd_tag         (comp_rd_tag),
        .outstanding         (outstanding),
        .err_tag             (err_tag),
        .err_spurious        (err_spurious),
        .err_commit          (err_commit),
        .err_timeout         (err_timeout),
        .err_clear           (err_clear)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: each entry lives in exactly one queue, in ring order.
    logic [31:0] m_unc[$];   // allocated, not yet committed
    logic [31:0] m_wq[$];    // committed, waiting for a completion message
    logic [31:0] m_dq[$];    // completion written, waiting for host retire
    logic [31:0] m_issue_tag;
    int          m_alloc_cnt;
    int          m_retire_cnt;
    int          m_idle;
    bit          m_db;
    bit          m_e_tag, m_e_spur, m_e_commit, m_e_to;

    function automatic logic [31:0] tag_after(input logic [31:0] t);
        return (t == 32'hFFFF_FFFF) ? 32'h1 : t + 32'h1;
    endfunction

    function automatic logic [31:0] head_tag();
        return (m_dq.size() != 0) ? m_dq[0] : 32'h0;
    endfunction

    function automatic int m_outst();
        return m_unc.size() + m_wq.size() + m_dq.size();
    endfunction

    // Next tag to retire is the oldest live entry, or the next one to be issued.
    function automatic logic [31:0] m_exp_tag();
        if (m_dq.size() != 0)  return m_dq[0];
        if (m_wq.size() != 0)  return m_wq[0];
        if (m_unc.size() != 0) return m_unc[0];
        return m_issue_tag;
    endfunction

    task automatic model_reset();
        m_unc.delete(); m_wq.delete(); m_dq.delete();
        m_issue_tag = P_TAG0; m_alloc_cnt = 0; m_retire_cnt = 0; m_idle = 0;
        m_db = 0; m_e_tag = 0; m_e_spur = 0; m_e_commit = 0; m_e_to = 0;
    endtask

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", name, obs, exp);
        end
    endtask

    task automatic check_all();
        bit rdy;
        rdy = cfg_enable && (m_outst() < P_SUB) && (m_unc.size() == 0);
        chk("alloc_ready", 64'(alloc_ready), 64'(rdy));
        chk("alloc_tag", 64'(alloc_tag), 64'(m_issue_tag));
        chk("alloc_addr", alloc_addr, cfg_submit_base + 64'((m_alloc_cnt % P_SUB) * P_SDB));
        chk("doorbell", 64'(cai_submit_doorbell), 64'(m_db));
        chk("comp_valid", 64'(comp_valid), 64'(m_dq.size() != 0));
        chk("comp_addr", comp_addr, cfg_comp_base + 64'((m_retire_cnt % P_COMP) * P_CRB));
        chk("comp_exp_tag", 64'(comp_exp_tag), 64'(m_exp_tag()));
        chk("outstanding", 64'(outstanding), 64'(m_outst()));
        chk("err_tag", 64'(err_tag), 64'(m_e_tag));
        chk("err_spurious", 64'(err_spurious), 64'(m_e_spur));
        chk("err_commit", 64'(err_commit), 64'(m_e_commit));
        chk("err_timeout", 64'(err_timeout), 64'(m_e_to));
        chk("submit_base", cai_submit_base, cfg_submit_base);
        chk("submit_size", 64'(cai_submit_size), 64'(P_SUB));
        chk("context_sel", 64'(cai_context_sel), 64'(cfg_context));
    endtask

    // Apply the rules of the ring to the inputs about to be clocked in.
    task automatic model_step();
        bit a, c, cbad, mok, mbad, ret, tbad, prog;
        a    = alloc_valid && cfg_enable && (m_outst() < P_SUB) && (m_unc.size() == 0);
        c    = commit && (m_unc.size() != 0);
        cbad = commit && (m_unc.size() == 0);
        mok  = cai_comp_msg && (m_wq.size() != 0);
        mbad = cai_comp_msg && (m_wq.size() == 0);
        ret  = comp_ready && (m_dq.size() != 0);
        tbad = ret && (comp_rd_tag != m_dq[0]);
        prog = cai_comp_msg || ret || err_clear || (m_wq.size() == 0);
        if (ret) begin
            void'(m_dq.pop_front());
            m_retire_cnt++;
        end
        if (mok) m_dq.push_back(m_wq.pop_front());
        if (c)   m_wq.push_back(m_unc.pop_front());
        if (a) begin
            m_unc.push_back(m_issue_tag);
            m_issue_tag = tag_after(m_issue_tag);
            m_alloc_cnt++;
        end
        if (prog) m_idle = 0;
        else if (m_idle < P_TOUT) m_idle++;
        if (err_clear) begin
            m_e_tag = 0; m_e_spur = 0; m_e_commit = 0; m_e_to = 0;
        end else begin
            if (tbad) m_e_tag = 1;
            if (mbad) m_e_spur = 1;
            if (cbad) m_e_commit = 1;
            if (!prog && m_idle == P_TOUT) m_e_to = 1;
        end
        m_db = c;
    endtask

    task automatic step(input bit av, input bit cm, input bit msg, input bit rdy,
                        input logic [31:0] rt, input bit clr);
        alloc_valid = av; commit = cm; cai_comp_msg = msg;
        comp_ready = rdy; comp_rd_tag = rt; err_clear = clr;
        model_step();
        @(negedge clk);
        check_all();
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 32'h0, 0);
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && m_outst() != 0; i++)
            step(0, m_unc.size() != 0, m_wq.size() != 0, m_dq.size() != 0, head_tag(), 0);
        chk("drained", 64'(outstanding), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 0; cfg_enable = 1; cfg_submit_base = 64'h400; cfg_comp_base = 64'h8000;
        cfg_context = 16'hC0DE; alloc_valid = 0; commit = 0; cai_comp_msg = 0;
        comp_ready = 0; comp_rd_tag = 0; err_clear = 0;
        model_reset();
        repeat (3) @(negedge clk);
        chk("ready_in_reset", 64'(alloc_ready), 64'd0);
        chk("doorbell_in_reset", 64'(cai_submit_doorbell), 64'd0);
        chk("comp_valid_in_reset", 64'(comp_valid), 64'd0);
        rst_n = 1;
        #1;
        check_all();
        chk("first_tag", 64'(alloc_tag), 64'hFFFF_FFFE);
        chk("first_addr", alloc_addr, 64'h400);

        // Error flags: bad commit, spurious completion, then clear.
        step(0, 1, 0, 0, 32'h0, 0);
        chk("err_commit_set", 64'(err_commit), 64'd1);
        step(0, 0, 1, 0, 32'h0, 0);
        chk("err_spur_set", 64'(err_spurious), 64'd1);
        chk("spur_no_pending", 64'(comp_valid), 64'd0);
        step(0, 0, 0, 0, 32'h0, 1);
        chk("err_cleared", 64'({err_commit, err_spurious}), 64'd0);

        // Single op across the tag wrap point.
        step(1, 0, 0, 0, 32'h0, 0);
        step(0, 1, 0, 0, 32'h0, 0);
        chk("doorbell_pulse", 64'(cai_submit_doorbell), 64'd1);
        step(0, 0, 1, 0, 32'h0, 0);
        chk("doorbell_low", 64'(cai_submit_doorbell), 64'd0);
        chk("comp_addr_first", comp_addr, 64'h8000);
        chk("comp_tag_first", 64'(comp_exp_tag), 64'hFFFF_FFFE);
        step(0, 0, 0, 1, 32'hFFFF_FFFE, 0);
        chk("outst_zero", 64'(outstanding), 64'd0);
        chk("second_tag", 64'(alloc_tag), 64'hFFFF_FFFF);
        step(1, 0, 0, 0, 32'h0, 0);
        chk("wrapped_tag", 64'(alloc_tag), 64'h1);
        step(0, 1, 0, 0, 32'h0, 0);
        step(0, 0, 1, 0, 32'h0, 0);
        step(0, 0, 0, 1, 32'hFFFF_FFFF, 0);
        step(1, 0, 0, 0, 32'h0, 0);
        step(0, 1, 0, 0, 32'h0, 0);
        step(0, 0, 1, 0, 32'h0, 0);
        step(0, 0, 0, 1, 32'h0, 0);
        chk("err_tag_on_zero", 64'(err_tag), 64'd1);
        step(0, 0, 0, 0, 32'h0, 1);

        // Fill the ring, then wrap the slot index.
        for (int i = 0; i < P_SUB; i++) begin
            step(1, 0, 0, 0, 32'h0, 0);
            step(0, 1, 0, 0, 32'h0, 0);
        end
        chk("ring_full_ready", 64'(alloc_ready), 64'd0);
        for (int i = 0; i < P_SUB; i++) step(0, 0, 1, 0, 32'h0, 0);
        step(0, 0, 0, 1, head_tag(), 0);
        step(0, 0, 0, 1, head_tag(), 0);
        for (int i = 0; i < 2; i++) begin
            step(1, 0, 0, 0, 32'h0, 0);
            step(0, 1, 0, 0, 32'h0, 0);
        end
        step(0, 0, 0, 1, head_tag(), 0);
        // One pending plus a same-cycle message and retire: stays pending.
        chk("pend_before", 64'(comp_valid), 64'd1);
        step(0, 0, 1, 1, head_tag(), 0);
        chk("simul_valid", 64'(comp_valid), 64'd1);
        drain();

        // Timeout: commit one op and withhold its completion.
        step(1, 0, 0, 0, 32'h0, 0);
        step(0, 1, 0, 0, 32'h0, 0);
        chk("to_doorbell", 64'(cai_submit_doorbell), 64'd1);
        repeat (P_TOUT - 1) idle();
        chk("to_not_yet", 64'(err_timeout), 64'd0);
        idle();
        chk("to_set", 64'(err_timeout), 64'd1);
        step(0, 0, 1, 0, 32'h0, 0);
        chk("to_sticky", 64'(err_timeout), 64'd1);
        step(0, 0, 0, 1, head_tag(), 0);
        step(0, 0, 0, 0, 32'h0, 1);
        chk("to_cleared", 64'(err_timeout), 64'd0);

        // Randomized traffic against the model.
        cfg_submit_base = {$urandom, $urandom};
        cfg_comp_base   = {$urandom, $urandom};
        cfg_context     = 16'($urandom);
        #1;
        check_all();
        for (int i = 0; i < 800; i++) begin
            cfg_enable = ($urandom_range(0, 7) != 0);
            step($urandom_range(0, 1) == 1,
                 $urandom_range(0, 2) == 0,
                 $urandom_range(0, 2) == 0,
                 $urandom_range(0, 2) == 0,
                 ($urandom_range(0, 9) == 0) ? 32'($urandom) : head_tag(),
                 $urandom_range(0, 15) == 0);
        end
        cfg_enable = 1;
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/carbon_cai_host_ring.md
# carbon_cai_host_ring

Synthesizable host-side CAI ring manager for Carbon systems. It turns the single-entry submit/doorbell/poll sequence into a multi-entry, in-order ring engine. It allocates submit-ring slots and tags, pulses the CAI submit doorbell, counts completion messages and exposes completion-record addresses with expected tags. It also flags tag mismatch, spurious completion and completion timeout. It sits between a host agent (CPU glue or DMA sequencer) and the `cai_link` host configuration/doorbell signals.

## Interface
Parameters:
- SUBMIT_DEPTH, 4: submit ring entries; power of two, 1..256
- COMP_DEPTH, 4: completion ring entries; power of two, ≥ SUBMIT_DEPTH
- SUBMIT_DESC_BYTES, 64: submit descriptor stride in bytes
- COMP_REC_BYTES, 32: completion record stride in bytes
- TAG_INIT, 32'h1: first tag issued; must be nonzero
- TIMEOUT_CYCLES, 20000: no-progress cycles before timeout; ≥ 1

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous, active-low reset
- cfg_enable  in  1  permits new allocations
- cfg_submit_base  in  64  submit ring base byte address
- cfg_comp_base  in  64  completion ring base byte address
- cfg_context  in  16  context id, passed through
- alloc_valid  in  1  host requests a slot
- alloc_ready  out  1  slot grant available
- alloc_tag  out  32  tag for granted slot
- alloc_addr  out  64  descriptor byte address for granted slot
- commit  in  1  one-cycle pulse: descriptor written, ring it
- cai_submit_base  out  64  equals cfg_submit_base
- cai_submit_size  out  32  constant SUBMIT_DEPTH
- cai_context_sel  out  16  equals cfg_context
- cai_submit_doorbell  out  1  one-cycle doorbell pulse
- cai_comp_msg  in  1  one-cycle pulse per completion record written
- comp_valid  out  1  a completion is pending
- comp_ready  in  1  host retires head completion
- comp_addr  out  64  head completion record byte address
- comp_exp_tag  out  32  tag the head record must carry
- comp_rd_tag  in  32  tag the host read, sampled on retire
- outstanding  out  9  allocated but not retired entries
- err_tag, err_spurious, err_commit, err_timeout  out  1 each  sticky errors
- err_clear  in  1  clears all sticky errors and the timeout counter

## Operation
- State: alloc_idx, commit_idx, retire_idx (9-bit wrap counters), pending (9b), issue_tag, exp_tag (32b), timer, error flags.
- outstanding = alloc_idx − retire_idx. inflight = commit_idx − retire_idx − pending.
- alloc_ready = cfg_enable && outstanding < SUBMIT_DEPTH && alloc_idx == commit_idx. Only one uncommitted slot exists at a time.
- alloc_tag = issue_tag. alloc_addr = cfg_submit_base + (alloc_idx mod SUBMIT_DEPTH)·SUBMIT_DESC_BYTES, computed in 64-bit arithmetic.
- On alloc_valid && alloc_ready: alloc_idx++ and issue_tag advances. Tag advance is +1, except 32'hFFFF_FFFF wraps to 32'h1; tag 0 is never issued.
- commit when alloc_idx == commit_idx: set err_commit and ignore the pulse. Otherwise commit_idx++ and doorbell fires.
- cai_comp_msg when inflight == 0: set err_spurious and ignore. Otherwise pending++.
- comp_valid = pending > 0. comp_addr = cfg_comp_base + (retire_idx mod COMP_DEPTH)·COMP_REC_BYTES. comp_exp_tag = exp_tag.
- On comp_valid && comp_ready: pending−−, retire_idx++, exp_tag advances by the same rule as issue_tag. If comp_rd_tag ≠ exp_tag, set err_tag; retirement still proceeds.
- Simultaneous cai_comp_msg and retire: pending is unchanged, and both take effect.
- Timer: cleared on comp_msg, on retire, on err_clear, or when inflight == 0. Otherwise it increments. At TIMEOUT_CYCLES it sets err_timeout and holds.
- Errors never block the datapath. err_clear has priority over a same-cycle error set.
- Dropping cfg_enable only stops new allocations. In-flight work drains normally.

## Timing
- Reset values:
  - alloc_ready 0 during reset; it follows its equation from the first cycle after release.
  - Indices, pending and timer 0. issue_tag and exp_tag = TAG_INIT. All err_* 0. Doorbell 0, comp_valid 0.
- Doorbell is registered: it is high exactly the cycle after an accepted commit.
- Completion visibility: comp_valid rises the cycle after cai_comp_msg.
- Back-to-back throughput: alloc → commit → alloc takes 1 slot per 2 cycles minimum.
- alloc_tag, alloc_addr, comp_addr and comp_exp_tag are combinational from registers plus cfg bases. They are stable while the corresponding valid is held.

## Test plan
- Single op: SUBMIT_DEPTH=1, alloc, then commit. Expect alloc_tag=1 and alloc_addr=submit_base, and a doorbell pulse on the next cycle. Then comp_msg and retire with rd_tag=1: comp_addr=comp_base, outstanding returns to 0, no errors.
- Ring wrap: SUBMIT_DEPTH=4, submit_base=0x400. Run 6 ops. Slot 5 addr = 0x440 (index 4 mod 4 = 0 → 0x400; index 5 → 0x440). Tags run 1..6. After 4 unretired allocations, alloc_ready=0.
- Tag wrap: TAG_INIT=32'hFFFF_FFFE. Issue 3 tags and expect FFFF_FFFE, FFFF_FFFF, 0000_0001. Retiring with rd_tag=0 sets err_tag.
- Errors: commit with no allocation → err_commit. comp_msg with inflight=0 → err_spurious, pending stays 0. err_clear clears both the next cycle.
- Timeout: TIMEOUT_CYCLES=100, commit one op, withhold comp_msg. err_timeout rises 100 cycles after the doorbell. A subsequent comp_msg clears the timer but not the flag.
- Simultaneous: pending=1, comp_msg and comp_ready in the same cycle. pending stays 1, retire_idx advances, comp_valid remains high.
